// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM with lane alignment, extension and timeout
module load_store_unit #(
  parameter int DBUS = 32,
  parameter int ABUS = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [ABUS-1:0] base,
  input  logic [ABUS-1:0] offset,
  input  logic [DBUS-1:0] wdata,
  output logic            stall,
  output logic            rsp_valid,
  output logic [DBUS-1:0] rdata,
  output logic            misalign,
  output logic            timeout,
  output logic [ABUS-1:0] addressData,
  output logic [DBUS-1:0] storeData,
  output logic [DBUS/8-1:0] mem_be,
  output logic            MWE,
  output logic            MRE,
  input  logic            mem_ready,
  input  logic [DBUS-1:0] loadedData
);
  localparam int NB = DBUS / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [ABUS-1:0] ea, ea_r;
  logic [1:0] size_r;
  logic signed_r, we_r, misalign_r, timeout_r, bad, acc, expired;
  logic [DBUS-1:0] wdata_r, shifted, loaded;
  logic [CW-1:0] cnt;
  logic [LB-1:0] lane;
  logic [NB-1:0] be_base;
  assign ea = base + offset;
  assign acc = state == ACCESS;
  assign lane = ea_r[LB-1:0];
  assign expired = cnt == CW'(MAX_WAIT - 1);
  // misalignment of the incoming request, decided at acceptance
  always_comb begin
    bad = (req_size == 2'b01 && ea[0]) || (req_size == 2'b10 && ea[LB-1:0] != '0) || req_size == 2'b11;
  end
  // next-state selection; a timeout fires on the cycle the counter would reach MAX_WAIT
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_valid ? (bad ? RESP : ACCESS) : IDLE)
            : acc ? ((mem_ready || expired) ? RESP : ACCESS)
            : IDLE;
  end
  // memory-side outputs live only in ACCESS; load data is right-aligned then extended
  always_comb begin
    be_base = size_r == 2'b00 ? NB'(1) : size_r == 2'b01 ? NB'(3) : {NB{1'b1}};
    shifted = loadedData >> {lane, 3'b000};
    loaded = size_r == 2'b00 ? {{(DBUS-8){signed_r & shifted[7]}}, shifted[7:0]}
           : size_r == 2'b01 ? {{(DBUS-16){signed_r & shifted[15]}}, shifted[15:0]}
           : shifted;
    stall = acc;
    rsp_valid = state == RESP;
    misalign = rsp_valid & misalign_r;
    timeout = rsp_valid & timeout_r;
    MWE = acc & we_r;
    MRE = acc & ~we_r;
    mem_be = acc ? be_base << lane : '0;
    addressData = acc ? ea_r & ~ABUS'(NB - 1) : '0;
    storeData = acc ? (size_r == 2'b00 ? DBUS'(wdata_r[7:0]) : size_r == 2'b01 ? DBUS'(wdata_r[15:0]) : wdata_r) << {lane, 3'b000} : '0;
  end
  // request capture, wait counting and load result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      ea_r <= '0;
      size_r <= '0;
      signed_r <= 1'b0;
      we_r <= 1'b0;
      wdata_r <= '0;
      misalign_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        ea_r <= ea;
        size_r <= req_size;
        signed_r <= req_signed;
        we_r <= req_we;
        wdata_r <= wdata;
        misalign_r <= bad;
        timeout_r <= 1'b0;
        cnt <= '0;
      end
      if (acc && mem_ready && !we_r) rdata <= loaded;
      if (acc && !mem_ready) begin
        cnt <= cnt + CW'(1);
        if (expired) begin
          timeout_r <= 1'b1;
          rdata <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_signed = 0, mem_ready = 0;
  logic [1:0] req_size = 0;
  logic [31:0] base = 0, offset = 0, wdata = 0, loadedData = 0;
  logic stall, rsp_valid, misalign, timeout, MWE, MRE;
  logic [31:0] rdata, addressData, storeData;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;

  load_store_unit #(.DBUS(32), .ABUS(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .base(base), .offset(offset), .wdata(wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rdata(rdata), .misalign(misalign), .timeout(timeout),
    .addressData(addressData), .storeData(storeData), .mem_be(mem_be), .MWE(MWE), .MRE(MRE),
    .mem_ready(mem_ready), .loadedData(loadedData));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd);
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn; base = b; offset = o; wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if ({stall, rsp_valid, misalign, timeout, MWE, MRE} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {stall, rsp_valid, misalign, timeout, MWE, MRE}); end
    checks++; if ({rdata, addressData, storeData, mem_be} !== 100'b0) begin errors++; $display("FAIL reset_buses got %h/%h/%h/%b want 0", rdata, addressData, storeData, mem_be); end
    rst = 0;
  endtask

  task automatic test_store_word();
    mem_ready = 1;
    issue(1, 2'b10, 0, 32'h4, 32'h8, 32'h9);
    tick(); req_valid = 0;
    checks++; if (addressData !== 32'h0C) begin errors++; $display("FAIL sw_addr got %h want 0000000c", addressData); end
    checks++; if (storeData !== 32'h9) begin errors++; $display("FAIL sw_data got %h want 00000009", storeData); end
    checks++; if ({mem_be, MWE, MRE, stall} !== 7'b1111_101) begin errors++; $display("FAIL sw_ctrl got %b want 1111101", {mem_be, MWE, MRE, stall}); end
    tick();
    checks++; if ({rsp_valid, stall, MWE, misalign, timeout} !== 5'b10000) begin errors++; $display("FAIL sw_resp got %b want 10000", {rsp_valid, stall, MWE, misalign, timeout}); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_idle got %b want 0", rsp_valid); end
  endtask

  task automatic test_byte_load();
    mem_ready = 1; loadedData = 32'h80FF0000;
    issue(0, 2'b00, 1, 32'h10, 32'h3, 32'h0);
    tick(); req_valid = 0;
    checks++; if ({addressData, mem_be, MRE, MWE} !== {32'h10, 4'b1000, 2'b10}) begin errors++; $display("FAIL lb_access got %h %b %b%b want 00000010 1000 10", addressData, mem_be, MRE, MWE); end
    tick();
    checks++; if ({rsp_valid, rdata} !== {1'b1, 32'hFFFFFF80}) begin errors++; $display("FAIL lb_signed got %b %h want 1 ffffff80", rsp_valid, rdata); end
    tick();
    issue(0, 2'b00, 0, 32'h10, 32'h3, 32'h0);
    tick(); req_valid = 0; tick();
    checks++; if ({rsp_valid, rdata} !== {1'b1, 32'h00000080}) begin errors++; $display("FAIL lbu got %b %h want 1 00000080", rsp_valid, rdata); end
    tick();
  endtask

  task automatic test_half_store();
    mem_ready = 1;
    issue(1, 2'b01, 0, 32'h2, 32'h4, 32'h1234ABCD);
    tick(); req_valid = 0;
    checks++; if ({storeData, mem_be, addressData} !== {32'hABCD0000, 4'b1100, 32'h4}) begin errors++; $display("FAIL sh got %h %b %h want abcd0000 1100 00000004", storeData, mem_be, addressData); end
    tick();
    checks++; if (rdata !== 32'h80) begin errors++; $display("FAIL sh_rdata_hold got %h want 00000080", rdata); end
    tick();
  endtask

  task automatic test_misalign();
    issue(0, 2'b10, 0, 32'h0, 32'h2, 32'h0);
    #1;
    checks++; if ({MWE, MRE} !== 2'b00) begin errors++; $display("FAIL mis_idle_mem got %b want 00", {MWE, MRE}); end
    tick(); req_valid = 0;
    checks++; if ({rsp_valid, misalign, timeout, MWE, MRE, stall} !== 6'b110000) begin errors++; $display("FAIL mis_word got %b want 110000", {rsp_valid, misalign, timeout, MWE, MRE, stall}); end
    checks++; if (rdata !== 32'h80) begin errors++; $display("FAIL mis_rdata got %h want 00000080", rdata); end
    tick();
    checks++; if ({rsp_valid, misalign} !== 2'b00) begin errors++; $display("FAIL mis_clear got %b want 00", {rsp_valid, misalign}); end
    issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0);
    tick(); req_valid = 0;
    checks++; if ({rsp_valid, misalign, MRE} !== 3'b110) begin errors++; $display("FAIL mis_rsvd got %b want 110", {rsp_valid, misalign, MRE}); end
    issue(0, 2'b01, 0, 32'h0, 32'h3, 32'h0);
    tick(); tick(); req_valid = 0;
    checks++; if ({rsp_valid, misalign} !== 2'b11) begin errors++; $display("FAIL mis_half got %b want 11", {rsp_valid, misalign}); end
    tick();
  endtask

  task automatic test_loads_misc();
    mem_ready = 1; loadedData = 32'h80010000;
    issue(0, 2'b01, 1, 32'h0, 32'h2, 32'h0);
    tick(); req_valid = 0;
    checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", mem_be); end
    tick();
    checks++; if (rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_signed got %h want ffff8001", rdata); end
    tick();
    loadedData = 32'hDEADBEEF;
    issue(0, 2'b10, 1, 32'hFFFFFFFC, 32'h8, 32'h0);
    tick(); req_valid = 0;
    checks++; if (addressData !== 32'h4) begin errors++; $display("FAIL wrap_addr got %h want 00000004", addressData); end
    tick();
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw got %h want deadbeef", rdata); end
    tick();
  endtask

  task automatic test_timeout();
    mem_ready = 0;
    issue(0, 2'b10, 0, 32'h20, 32'h0, 32'h0);
    tick(); req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({MRE, stall, rsp_valid} !== 3'b110) begin errors++; $display("FAIL to_wait%0d got %b want 110", i, {MRE, stall, rsp_valid}); end
      tick();
    end
    checks++; if ({rsp_valid, timeout, misalign, MRE, rdata} !== {4'b1100, 32'h0}) begin errors++; $display("FAIL to_resp got %b %b %b %b %h want 1 1 0 0 00000000", rsp_valid, timeout, misalign, MRE, rdata); end
    tick();
    checks++; if ({rsp_valid, timeout} !== 2'b00) begin errors++; $display("FAIL to_clear got %b want 00", {rsp_valid, timeout}); end
  endtask

  task automatic test_reset_mid_access();
    mem_ready = 0;
    issue(0, 2'b10, 0, 32'h40, 32'h0, 32'h0);
    tick(); req_valid = 0;
    tick();
    checks++; if (MRE !== 1'b1) begin errors++; $display("FAIL rma_access got %b want 1", MRE); end
    rst = 1;
    tick(); rst = 0;
    checks++; if ({stall, rsp_valid, MWE, MRE, mem_be, addressData, storeData, rdata} !== 104'b0) begin errors++; $display("FAIL rma_zero got %b%b%b%b %b %h %h %h want 0", stall, rsp_valid, MWE, MRE, mem_be, addressData, storeData, rdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rma_norsp%0d got %b want 0", i, rsp_valid); end
    end
    mem_ready = 1;
    issue(1, 2'b00, 0, 32'h0, 32'h1, 32'h1234565A);
    tick(); req_valid = 0;
    checks++; if ({storeData, mem_be, MWE} !== {32'h00005A00, 4'b0010, 1'b1}) begin errors++; $display("FAIL rma_store got %h %b %b want 00005a00 0010 1", storeData, mem_be, MWE); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rma_done got %b want 1", rsp_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1;
    issue(1, 2'b10, 0, 32'h8, 32'h0, 32'h77);
    tick();
    checks++; if ({stall, MWE} !== 2'b11) begin errors++; $display("FAIL b2b_acc1 got %b want 11", {stall, MWE}); end
    tick();
    checks++; if ({rsp_valid, stall, MWE} !== 3'b100) begin errors++; $display("FAIL b2b_resp got %b want 100", {rsp_valid, stall, MWE}); end
    tick();
    checks++; if ({rsp_valid, stall} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b want 00", {rsp_valid, stall}); end
    tick(); req_valid = 0;
    checks++; if ({stall, MWE, storeData} !== {2'b11, 32'h77}) begin errors++; $display("FAIL b2b_acc2 got %b %h want 11 00000077", {stall, MWE}, storeData); end
    tick(); tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_store_word();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_loads_misc();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DBUS, default 32: data bus width in bits; SHALL be a power of two, at least 16 and a multiple of 8.
REQ-002 Parameter ABUS, default 32: address width in bits.
REQ-003 Parameter MAX_WAIT, default 15: maximum ACCESS cycles before timeout; SHALL be at least 1.
REQ-004 Derived constants: NB = DBUS/8 (byte lanes) and LB = log2(NB).
REQ-005 Port list:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  pipeline access request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half (16b), 10 full bus (DBUS), 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- base  in  ABUS  base register value.
- offset  in  ABUS  offset register value.
- wdata  in  DBUS  store data, right-aligned.
- stall  out  1  pipeline hold.
- rsp_valid  out  1  one-cycle completion pulse.
- rdata  out  DBUS  load result.
- misalign  out  1  alignment error flag.
- timeout  out  1  memory timeout flag.
- addressData  out  ABUS  memory address, lane-aligned.
- storeData  out  DBUS  lane-positioned store data.
- mem_be  out  NB  byte enables.
- MWE  out  1  memory write enable.
- MRE  out  1  memory read enable.
- mem_ready  in  1  memory completion.
- loadedData  in  DBUS  memory read data.

Function
REQ-006 The effective address SHALL be ea = base + offset, computed modulo 2^ABUS; carry-out is discarded.
REQ-007 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-008 In IDLE with req_valid=1, the request SHALL be accepted: ea, size, signedness, direction, lane and data are registered.
- The next state SHALL be ACCESS if the access is aligned.
- The next state SHALL be RESP with misalign=1 otherwise.
REQ-009 An access SHALL be misaligned when any of the following holds:
- size 01 and ea[0] is nonzero;
- size 10 and ea[LB-1:0] is nonzero;
- size 11.
REQ-010 req_valid SHALL be ignored in ACCESS and RESP; no request queueing.
REQ-011 In ACCESS:
- addressData SHALL equal ea with bits [LB-1:0] cleared.
- Exactly one of MWE and MRE SHALL be 1, per req_we.
- mem_be SHALL be 1 exactly for the accessed lanes, starting at lane ea[LB-1:0].
REQ-012 Store data SHALL be placed as follows:
- storeData SHALL hold the low 8, 16 or DBUS bits of wdata shifted to byte lane ea[LB-1:0].
- All other storeData bits SHALL be 0.
REQ-013 In ACCESS with mem_ready=1, the next state SHALL be RESP.
- For loads, rdata SHALL capture the selected lanes of loadedData, right-aligned.
- The captured value SHALL be sign- or zero-extended per req_signed.
REQ-014 Each ACCESS cycle with mem_ready=0 SHALL increment a wait counter; the counter clears on entry to ACCESS.
REQ-015 When the counter reaches MAX_WAIT, the next state SHALL be RESP with timeout=1 and rdata=0.
REQ-016 RESP SHALL last exactly one cycle: rsp_valid=1, then return to IDLE.
REQ-017 In RESP, misalign and timeout SHALL be valid, and both SHALL be 0 in every other state.
REQ-018 stall SHALL be 1 in ACCESS and 0 in IDLE and RESP.
REQ-019 MWE, MRE, mem_be, addressData and storeData SHALL be 0 outside ACCESS.
REQ-020 rdata SHALL hold its value until the next load completion, reset or timeout.
REQ-021 For stores, rdata SHALL be left unchanged.
REQ-022 Latency from acceptance at cycle N with immediate mem_ready SHALL be: ACCESS at N+1, RESP at N+2.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE, clear the wait counter and set every output to 0, regardless of current state.
REQ-024 A reset during ACCESS SHALL drop MWE/MRE at that edge and produce no rsp_valid for the aborted request.
REQ-025 The first request SHALL be accepted in the first cycle in which rst=0 and req_valid=1.

Verification
REQ-026 Store full word: DBUS=32, base=4, offset=8, wdata=9, mem_ready=1 -> ACCESS cycle shows addressData=0x0C, storeData=9, mem_be=1111, MWE=1, MRE=0, stall=1; rsp_valid=1 on the next cycle.
REQ-027 Signed byte load: base=0x10, offset=3, loadedData=0x80FF0000 -> addressData=0x10, mem_be=1000, rdata=0xFFFFFF80; the same load with req_signed=0 -> rdata=0x00000080.
REQ-028 Half store: ea=0x06, wdata=0x1234ABCD -> storeData=0xABCD0000, mem_be=1100, addressData=0x04.
REQ-029 Misaligned word: ea=0x02 -> MWE and MRE never 1; the next cycle shows RESP with rsp_valid=1 and misalign=1.
REQ-030 Timeout: MAX_WAIT=4, load with mem_ready held 0 -> MRE=1 for 4 cycles, then rsp_valid=1, timeout=1, rdata=0.
REQ-031 Reset mid-access: rst asserted in the 2nd ACCESS cycle -> all outputs 0 on the next cycle and no rsp_valid; after rst drops, a new store is accepted and completes normally.
